// File: rtl/rvfi_regset_check.sv
// rvfi_regset_check
// Shadows NTRACK architectural registers from retired rd writes and checks
// every tracked rs1/rs2 read against the shadow. It also checks that x0
// reads return zero and that writes to x0 carry zero data. Errors are
// reported on registered outputs: a one-cycle pulse with the first error's
// details, a sticky flag and a saturating error counter.
//
// Handshake: rvfi_valid[k] qualifies every channel-k field in the same
// cycle. There is no ready/backpressure, so a valid channel is always
// consumed on the clock edge where it is presented.
module rvfi_regset_check #(
    parameter int XLEN      = 32,
    parameter int NRET      = 1,
    parameter int NTRACK    = 4,
    parameter int ZERO_INIT = 0,
    parameter int CHECK_X0  = 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 check,
    input  logic [NTRACK*5-1:0]  track_idx,
    input  logic [NRET-1:0]      rvfi_valid,
    input  logic [NRET*5-1:0]    rvfi_rs1_addr,
    input  logic [NRET*5-1:0]    rvfi_rs2_addr,
    input  logic [NRET*5-1:0]    rvfi_rd_addr,
    input  logic [NRET*XLEN-1:0] rvfi_rs1_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rs2_rdata,
    input  logic [NRET*XLEN-1:0] rvfi_rd_wdata,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [7:0]           err_chan,
    output logic [4:0]           err_reg,
    output logic                 err_any,
    output logic [15:0]          err_count
);

    localparam logic [1:0] CODE_X0_READ  = 2'd2;
    localparam logic [1:0] CODE_X0_WRITE = 2'd3;

    // Shadow state per tracked slot.
    logic [XLEN-1:0]   shadow_q  [NTRACK];
    logic [NTRACK-1:0] written_q;

    // Next-state shadow, built up channel by channel within one cycle.
    logic [XLEN-1:0]   shadow_n  [NTRACK];
    logic [NTRACK-1:0] written_n;

    // Errors found in the current cycle and the highest-priority one.
    logic [31:0]       hit_cnt;
    logic              hit;
    logic [1:0]        hit_code;
    logic [7:0]        hit_chan;
    logic [4:0]        hit_reg;

    // Per-channel views of the two read ports and the write port.
    logic [1:0][4:0]      rs_addr;
    logic [1:0][XLEN-1:0] rs_data;
    logic [4:0]           rd_addr;
    logic [XLEN-1:0]      rd_data;
    logic [4:0]           slot_idx;

    // Saturating counter update.
    logic [31:0]       count_sum;

    // Walk channels in ascending order: reads of a channel see writes of
    // lower channels, then the channel's own write lands in the shadow.
    always_comb begin
        shadow_n  = shadow_q;
        written_n = written_q;
        hit_cnt   = 32'd0;
        hit       = 1'b0;
        hit_code  = 2'd0;
        hit_chan  = 8'd0;
        hit_reg   = 5'd0;
        rs_addr   = '0;
        rs_data   = '0;
        rd_addr   = 5'd0;
        rd_data   = '0;
        slot_idx  = 5'd0;

        for (int k = 0; k < NRET; k++) begin
            if (rvfi_valid[k]) begin
                rs_addr[0] = rvfi_rs1_addr[k*5 +: 5];
                rs_addr[1] = rvfi_rs2_addr[k*5 +: 5];
                rs_data[0] = rvfi_rs1_rdata[k*XLEN +: XLEN];
                rs_data[1] = rvfi_rs2_rdata[k*XLEN +: XLEN];
                rd_addr    = rvfi_rd_addr[k*5 +: 5];
                rd_data    = rvfi_rd_wdata[k*XLEN +: XLEN];

                // Read ports: rs1 first, then rs2, so priority falls out
                // of the loop order. Reads use the shadow before this
                // channel's own write.
                for (int r = 0; r < 2; r++) begin
                    if ((CHECK_X0 != 0) && check &&
                        (rs_addr[r] == 5'd0) && (rs_data[r] != '0)) begin
                        hit_cnt = hit_cnt + 32'd1;
                        if (!hit) begin
                            hit      = 1'b1;
                            hit_code = CODE_X0_READ;
                            hit_chan = 8'(k);
                            hit_reg  = 5'd0;
                        end
                    end
                    for (int s = 0; s < NTRACK; s++) begin
                        slot_idx = track_idx[s*5 +: 5];
                        if (check && (slot_idx != 5'd0) && written_n[s] &&
                            (rs_addr[r] == slot_idx) &&
                            (rs_data[r] != shadow_n[s])) begin
                            hit_cnt = hit_cnt + 32'd1;
                            if (!hit) begin
                                hit      = 1'b1;
                                hit_code = 2'(r);
                                hit_chan = 8'(k);
                                hit_reg  = slot_idx;
                            end
                        end
                    end
                end

                // Write port: x0 write check ranks after both reads.
                if ((CHECK_X0 != 0) && check &&
                    (rd_addr == 5'd0) && (rd_data != '0)) begin
                    hit_cnt = hit_cnt + 32'd1;
                    if (!hit) begin
                        hit      = 1'b1;
                        hit_code = CODE_X0_WRITE;
                        hit_chan = 8'(k);
                        hit_reg  = 5'd0;
                    end
                end

                // Shadow update happens regardless of check; a later
                // channel overwrites an earlier one in the same cycle.
                for (int s = 0; s < NTRACK; s++) begin
                    slot_idx = track_idx[s*5 +: 5];
                    if ((slot_idx != 5'd0) && (rd_addr == slot_idx)) begin
                        shadow_n[s]  = rd_data;
                        written_n[s] = 1'b1;
                    end
                end
            end
        end
    end

    // Saturating sum of the running count and this cycle's errors.
    always_comb begin
        count_sum = {16'd0, err_count} + hit_cnt;
        if (count_sum > 32'h0000_FFFF) begin
            count_sum = 32'h0000_FFFF;
        end
    end

    // Shadow registers; reset forgets every tracked value.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int s = 0; s < NTRACK; s++) begin
                shadow_q[s] <= '0;
            end
            written_q <= (ZERO_INIT != 0) ? {NTRACK{1'b1}} : {NTRACK{1'b0}};
        end else begin
            for (int s = 0; s < NTRACK; s++) begin
                shadow_q[s] <= shadow_n[s];
            end
            written_q <= written_n;
        end
    end

    // Registered error reporting: pulse, first-error fields, sticky, count.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            err       <= 1'b0;
            err_code  <= 2'd0;
            err_chan  <= 8'd0;
            err_reg   <= 5'd0;
            err_any   <= 1'b0;
            err_count <= 16'd0;
        end else begin
            err <= hit;
            if (hit) begin
                err_code <= hit_code;
                err_chan <= hit_chan;
                err_reg  <= hit_reg;
                err_any  <= 1'b1;
            end
            err_count <= count_sum[15:0];
        end
    end

endmodule

// File: tb/tb_rvfi_regset_check.sv
// Bench for rvfi_regset_check: two instances (multi-channel without
// zero-init, single-channel with zero-init) driven by directed vectors.
// Each vector carries its hand-computed response; a monitor per instance
// pops the expected response after each clock edge and compares.
module tb_rvfi_regset_check;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1a;
        logic [31:0] rs1d;
        logic [4:0]  rs2a;
        logic [31:0] rs2d;
        logic [4:0]  rda;
        logic [31:0] rdd;
    } ch_t;

    typedef struct packed {
        logic        chk;
        logic        err;
        logic [1:0]  code;
        logic [7:0]  chan;
        logic [4:0]  rg;
        logic        any;
        logic [15:0] cnt;
    } exp_t;

    localparam int EW = $bits(exp_t);

    // ---------------- clock / reset ----------------
    logic clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: NRET=2, slots {x5, x7, x5, unused}, ZERO_INIT=0.
    logic        resetn_a = 1'b0, check_a = 1'b0;
    logic [1:0]  valid_a = '0;
    logic [9:0]  rs1a_a = '0, rs2a_a = '0, rda_a = '0;
    logic [63:0] rs1d_a = '0, rs2d_a = '0, rdd_a = '0;
    logic        err_a, any_a;
    logic [1:0]  code_a;
    logic [7:0]  chan_a;
    logic [4:0]  reg_a;
    logic [15:0] cnt_a;
    logic [19:0] track_a = {5'd0, 5'd5, 5'd7, 5'd5};

    // Instance B: NRET=1, slots {x7, x5, unused, unused}, ZERO_INIT=1.
    logic        resetn_b = 1'b0, check_b = 1'b0;
    logic [0:0]  valid_b = '0;
    logic [4:0]  rs1a_b = '0, rs2a_b = '0, rda_b = '0;
    logic [31:0] rs1d_b = '0, rs2d_b = '0, rdd_b = '0;
    logic        err_b, any_b;
    logic [1:0]  code_b;
    logic [7:0]  chan_b;
    logic [4:0]  reg_b;
    logic [15:0] cnt_b;
    logic [19:0] track_b = {5'd0, 5'd0, 5'd5, 5'd7};

    rvfi_regset_check #(
        .XLEN(32), .NRET(2), .NTRACK(4), .ZERO_INIT(0), .CHECK_X0(1)
    ) dut_a (
        .clock(clock), .resetn(resetn_a), .check(check_a), .track_idx(track_a),
        .rvfi_valid(valid_a), .rvfi_rs1_addr(rs1a_a), .rvfi_rs2_addr(rs2a_a),
        .rvfi_rd_addr(rda_a), .rvfi_rs1_rdata(rs1d_a), .rvfi_rs2_rdata(rs2d_a),
        .rvfi_rd_wdata(rdd_a), .err(err_a), .err_code(code_a), .err_chan(chan_a),
        .err_reg(reg_a), .err_any(any_a), .err_count(cnt_a)
    );

    rvfi_regset_check #(
        .XLEN(32), .NRET(1), .NTRACK(4), .ZERO_INIT(1), .CHECK_X0(1)
    ) dut_b (
        .clock(clock), .resetn(resetn_b), .check(check_b), .track_idx(track_b),
        .rvfi_valid(valid_b), .rvfi_rs1_addr(rs1a_b), .rvfi_rs2_addr(rs2a_b),
        .rvfi_rd_addr(rda_b), .rvfi_rs1_rdata(rs1d_b), .rvfi_rs2_rdata(rs2d_b),
        .rvfi_rd_wdata(rdd_b), .err(err_b), .err_code(code_b), .err_chan(chan_b),
        .err_reg(reg_b), .err_any(any_b), .err_count(cnt_b)
    );

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp_qa[$];
    logic [EW-1:0] exp_qb[$];
    int n_pass  = 0;
    int n_total = 0;

    // Response model: holds report fields between errors, sticky flag,
    // saturating count. Index 0 = instance A, 1 = instance B.
    logic [1:0] m_code [2];
    logic [7:0] m_chan [2];
    logic [4:0] m_reg  [2];
    logic       m_any  [2];
    int         m_cnt  [2];

    ch_t nop_c;

    function automatic ch_t ch(input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] a2, input logic [31:0] d2,
                               input logic [4:0] ad, input logic [31:0] dd);
        ch_t c;
        c.valid = 1'b1;
        c.rs1a = a1; c.rs1d = d1;
        c.rs2a = a2; c.rs2d = d2;
        c.rda  = ad; c.rdd  = dd;
        return c;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    endtask

    // ---------------- driver ----------------
    // One cycle of stimulus for instance `which`, plus the expected
    // response after the following edge (e/code/chan/rg/add hand-derived).
    task automatic step(input int which, input ch_t c0, input ch_t c1,
                        input bit chk_en, input bit rst_n, input bit e,
                        input logic [1:0] code, input logic [7:0] chan,
                        input logic [4:0] rg, input int add, input bit do_cmp);
        exp_t x;
        @(negedge clock);
        if (which == 0) begin
            resetn_a = rst_n; check_a = chk_en;
            valid_a = {c1.valid, c0.valid};
            rs1a_a = {c1.rs1a, c0.rs1a}; rs1d_a = {c1.rs1d, c0.rs1d};
            rs2a_a = {c1.rs2a, c0.rs2a}; rs2d_a = {c1.rs2d, c0.rs2d};
            rda_a  = {c1.rda,  c0.rda};  rdd_a  = {c1.rdd,  c0.rdd};
        end else begin
            resetn_b = rst_n; check_b = chk_en;
            valid_b = c0.valid;
            rs1a_b = c0.rs1a; rs1d_b = c0.rs1d;
            rs2a_b = c0.rs2a; rs2d_b = c0.rs2d;
            rda_b  = c0.rda;  rdd_b  = c0.rdd;
        end
        if (!rst_n) begin
            m_code[which] = 2'd0; m_chan[which] = 8'd0; m_reg[which] = 5'd0;
            m_any[which] = 1'b0; m_cnt[which] = 0;
        end else begin
            if (e) begin
                m_code[which] = code; m_chan[which] = chan; m_reg[which] = rg;
                m_any[which] = 1'b1;
            end
            m_cnt[which] = (m_cnt[which] + add > 65535) ? 65535 : m_cnt[which] + add;
        end
        x.chk  = do_cmp;
        x.err  = e & rst_n;
        x.code = m_code[which];
        x.chan = m_chan[which];
        x.rg   = m_reg[which];
        x.any  = m_any[which];
        x.cnt  = 16'(m_cnt[which]);
        if (which == 0) exp_qa.push_back(x);
        else            exp_qb.push_back(x);
    endtask

    // ---------------- monitors ----------------
    exp_t xa, xb;

    always @(posedge clock) begin
        #1;
        if (exp_qa.size() > 0) begin
            xa = exp_t'(exp_qa.pop_front());
            if (xa.chk) begin
                cmp("a_err",   {31'd0, err_a},  {31'd0, xa.err});
                cmp("a_code",  {30'd0, code_a}, {30'd0, xa.code});
                cmp("a_chan",  {24'd0, chan_a}, {24'd0, xa.chan});
                cmp("a_reg",   {27'd0, reg_a},  {27'd0, xa.rg});
                cmp("a_any",   {31'd0, any_a},  {31'd0, xa.any});
                cmp("a_count", {16'd0, cnt_a},  {16'd0, xa.cnt});
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (exp_qb.size() > 0) begin
            xb = exp_t'(exp_qb.pop_front());
            if (xb.chk) begin
                cmp("b_err",   {31'd0, err_b},  {31'd0, xb.err});
                cmp("b_code",  {30'd0, code_b}, {30'd0, xb.code});
                cmp("b_chan",  {24'd0, chan_b}, {24'd0, xb.chan});
                cmp("b_reg",   {27'd0, reg_b},  {27'd0, xb.rg});
                cmp("b_any",   {31'd0, any_b},  {31'd0, xb.any});
                cmp("b_count", {16'd0, cnt_b},  {16'd0, xb.cnt});
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        nop_c = '0;
        for (int i = 0; i < 2; i++) begin
            m_code[i] = 2'd0; m_chan[i] = 8'd0; m_reg[i] = 5'd0;
            m_any[i] = 1'b0; m_cnt[i] = 0;
        end

        // Instance A: reset state
        step(0, nop_c, nop_c, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, nop_c, nop_c, 1, 0, 0, 0, 0, 0, 0, 1);
        // Write x5, matching read, then mismatching rs2 read (two x5 slots)
        step(0, ch(0, 0, 0, 0, 5, 32'h1234), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(5, 32'h1234, 0, 0, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(0, 0, 5, 32'h1235, 0, 0), nop_c, 1, 1, 1, 2'd1, 8'd0, 5'd5, 2, 1);
        step(0, nop_c, nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        // Channel 1 sees channel 0's write in the same cycle
        step(0, ch(0, 0, 0, 0, 5, 32'hA), ch(5, 32'hA, 0, 0, 0, 0), 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(0, 0, 0, 0, 5, 32'hA), ch(5, 32'hB, 0, 0, 0, 0), 1, 1, 1, 2'd0, 8'd1, 5'd5, 2, 1);
        // Same-channel read sees old value, write lands afterwards
        step(0, ch(5, 32'hA, 0, 0, 5, 32'hC), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(5, 32'hC, 0, 0, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        // x0 write and x0 read in one channel: read reported first
        step(0, ch(0, 32'h1, 0, 0, 0, 32'h9), nop_c, 1, 1, 1, 2'd2, 8'd0, 5'd0, 2, 1);
        // Tracked but never-written x7: no comparison
        step(0, ch(7, 32'h55, 0, 0, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        // check=0: shadow updates, no errors (including x0)
        step(0, ch(0, 0, 0, 0, 5, 32'h3), nop_c, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(5, 32'h99, 0, 0, 0, 32'h5), nop_c, 0, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(5, 32'h3, 0, 0, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        // Last channel's write wins
        step(0, ch(0, 0, 0, 0, 7, 32'h11), ch(0, 0, 0, 0, 7, 32'h22), 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(7, 32'h22, 0, 0, 0, 0), ch(0, 0, 7, 32'h11, 0, 0), 1, 1, 1, 2'd1, 8'd1, 5'd7, 1, 1);
        // Lower channel reported first; all three errors counted
        step(0, ch(0, 0, 5, 32'h4, 0, 0), ch(0, 32'h1, 0, 0, 0, 0), 1, 1, 1, 2'd1, 8'd0, 5'd5, 3, 1);
        // Drive the counter into saturation: 10 errors per cycle
        for (int i = 0; i < 6600; i++) begin
            step(0, ch(5, 32'h4, 5, 32'h4, 0, 32'h1), ch(5, 32'h4, 5, 32'h4, 0, 32'h1),
                 1, 1, 1, 2'd0, 8'd0, 5'd5, 10, 0);
        end
        step(0, ch(5, 32'h4, 5, 32'h4, 0, 32'h1), ch(5, 32'h4, 5, 32'h4, 0, 32'h1),
             1, 1, 1, 2'd0, 8'd0, 5'd5, 10, 1);
        // Mid-run reset clears everything and ignores inputs
        step(0, ch(5, 32'h4, 0, 0, 0, 32'h1), nop_c, 1, 0, 0, 0, 0, 0, 0, 1);
        step(0, ch(5, 32'h77, 5, 32'h77, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(0, 0, 0, 0, 5, 32'h8), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(0, ch(0, 0, 5, 32'h9, 0, 0), nop_c, 1, 1, 1, 2'd1, 8'd0, 5'd5, 2, 1);
        step(0, nop_c, nop_c, 1, 1, 0, 0, 0, 0, 0, 1);

        // Instance B: zero-initialised shadows
        step(1, nop_c, nop_c, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, nop_c, nop_c, 1, 0, 0, 0, 0, 0, 0, 1);
        step(1, ch(7, 32'h0, 5, 32'h0, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(1, ch(7, 32'h1, 0, 0, 0, 0), nop_c, 1, 1, 1, 2'd0, 8'd0, 5'd7, 1, 1);
        step(1, ch(0, 0, 0, 0, 7, 32'h40), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(1, ch(0, 0, 7, 32'h40, 0, 0), nop_c, 1, 1, 0, 0, 0, 0, 0, 1);
        step(1, ch(0, 0, 7, 32'h41, 0, 0), nop_c, 1, 1, 1, 2'd1, 8'd0, 5'd7, 1, 1);
        step(1, nop_c, nop_c, 1, 1, 0, 0, 0, 0, 0, 1);

        // Drain both scoreboards within a bounded number of cycles
        for (int i = 0; i < 20 && (exp_qa.size() > 0 || exp_qb.size() > 0); i++) begin
            @(posedge clock);
        end
        @(negedge clock);
        n_total++;
        if (exp_qa.size() == 0 && exp_qb.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d/%0d entries left expected 0/0",
                      exp_qa.size(), exp_qb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
